// File: rtl/dct_pkg.sv
// Shared definitions for the DCT result drain slice.
// Holds the default array geometry and data widths, the sequencer state
// encoding, the row/column index width, and a counter-width helper.
package dct_pkg;

   localparam int DEF_N     = 8;
   localparam int DEF_ACC_W = 32;
   localparam int DEF_OUT_W = 16;
   localparam int DEF_FRAC  = 14;
   localparam int IDX_W     = $clog2(DEF_N);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      ACCUM   = 3'd2,
      CAPTURE = 3'd3,
      DRAIN   = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Round-half-up and saturate a signed accumulator word to the output width.
// Ports:
//   acc : signed ACC_W-bit accumulator value
//   res : signed OUT_W-bit result, round(acc / 2^FRAC) clamped to range
// The sum is formed one bit wider than the accumulator so that adding the
// rounding constant to the most positive value cannot wrap negative.
module dct_round_sat #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int FRAC  = 14
) (
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] res
);

   localparam logic signed [ACC_W:0] RND    = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;

   // Sign-extend, add half an LSB, shift out the fraction, then clamp.
   always_comb begin
      sum     = $signed({acc[ACC_W-1], acc}) + RND;
      shifted = sum >>> FRAC;
      if (shifted > SAT_HI) begin
         res = SAT_HI[OUT_W-1:0];
      end else if (shifted < SAT_LO) begin
         res = SAT_LO[OUT_W-1:0];
      end else begin
         res = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/dct_result_drain.sv
// Sequencer and result drain for one N x N systolic DCT pass.
// Clears the PE array, opens the accumulation window, captures every PE
// accumulator into a local buffer, then streams rounded/saturated results
// row-major over a valid/ready handshake.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start               : begin a pass (only honoured in IDLE)
//   busy                : high whenever not IDLE
//   array_clr           : one-cycle synchronous clear to all PEs
//   feed_en             : upstream skew feeder presents operands
//   pe_result           : flattened accumulators, PE(r,c) at [(r*N+c)*ACC_W +: ACC_W]
//   out_data            : signed rounded/saturated coefficient
//   out_row, out_col    : position of out_data in the matrix
//   out_valid, out_ready: output handshake
//   done                : one-cycle pulse after the last transfer
// All outputs are registered; each is computed from the next state so the
// registered value lines up with the state it belongs to.
module dct_result_drain
   import dct_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int ACC_W      = DEF_ACC_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int FRAC       = DEF_FRAC,
   parameter int ACC_CYCLES = 3 * N - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   array_clr,
   output logic                   feed_en,
   input  logic [N*N*ACC_W-1:0]   pe_result,
   output logic [OUT_W-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [$clog2(N)-1:0]   out_col,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   done
);

   localparam int IW = $clog2(N);
   localparam int PW = $clog2(N * N);
   localparam int CW = cnt_width(ACC_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
   localparam logic [PW-1:0] IDX_LAST = PW'(N * N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [PW-1:0]    idx;
   logic [PW-1:0]    idx_nxt;
   logic [ACC_W-1:0] buffer [N*N];

   logic             busy_nxt;
   logic             clr_nxt;
   logic             feed_nxt;
   logic             valid_nxt;
   logic             done_nxt;
   logic [ACC_W-1:0] src_word;
   logic [OUT_W-1:0] rs_word;
   logic             xfer;

   assign xfer = out_valid && out_ready;

   // State, window counter and drain index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state, window counter and drain index logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CLEAR;
            end else begin
               state_nxt = IDLE;
            end
         end
         CLEAR: begin
            state_nxt = ACCUM;
            cnt_nxt   = '0;
         end
         ACCUM: begin
            if (cnt == CNT_LAST) begin
               state_nxt = CAPTURE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         CAPTURE: begin
            state_nxt = DRAIN;
            idx_nxt   = '0;
         end
         DRAIN: begin
            if (xfer) begin
               idx_nxt = idx + PW'(1);
               if (idx == IDX_LAST) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = DRAIN;
               end
            end else begin
               state_nxt = DRAIN;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Moore output decode from the next state, registered below.
   always_comb begin
      busy_nxt  = 1'b1;
      clr_nxt   = 1'b0;
      feed_nxt  = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      case (state_nxt)
         IDLE:    busy_nxt  = 1'b0;
         CLEAR:   clr_nxt   = 1'b1;
         ACCUM:   feed_nxt  = 1'b1;
         CAPTURE: busy_nxt  = 1'b1;
         DRAIN:   valid_nxt = 1'b1;
         DONE:    done_nxt  = 1'b1;
         default: busy_nxt  = 1'b0;
      endcase
   end

   // Word that will be presented next. On the capture edge the buffer is
   // being loaded in the same cycle, so word 0 comes straight from the array.
   always_comb begin
      if (state == CAPTURE) begin
         src_word = pe_result[0 +: ACC_W];
      end else begin
         src_word = buffer[idx_nxt];
      end
   end

   dct_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .FRAC  (FRAC)
   ) u_round_sat (
      .acc (src_word),
      .res (rs_word)
   );

   // Registered outputs; data and position hold while idx_nxt holds (stall).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         array_clr <= 1'b0;
         feed_en   <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         busy      <= busy_nxt;
         array_clr <= clr_nxt;
         feed_en   <= feed_nxt;
         out_valid <= valid_nxt;
         done      <= done_nxt;
         out_data  <= rs_word;
         out_row   <= IW'(int'(idx_nxt) / N);
         out_col   <= IW'(int'(idx_nxt) % N);
      end
   end

   // Result buffer, loaded from every PE at the end of the capture cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N * N; i++) begin
            buffer[i] <= '0;
         end
      end else if (state == CAPTURE) begin
         for (int i = 0; i < N * N; i++) begin
            buffer[i] <= pe_result[i*ACC_W +: ACC_W];
         end
      end
   end

endmodule
